ingress_rr_arbiter: RTL and testbench
=====================================

// Module: ingress_rr_arbiter
// PURPOSE
//  Per-node ingress stage of the ring interconnect. Accepts words from NUM_CH sources
//  (default left/self/right), buffers each source in its own FIFO, and forwards one word per
//  cycle to the node controller over a valid/ready handshake using fair round-robin.
//  Replaces fixed-rotation source sampling: no lost words while buffer space remains,
//  and the arbiter skips empty channels.
// PARAMETERS
//  WIDTH   32  data word width in bits
//  NUM_CH  3   number of source channels (>=2); ch0=left, ch1=self, ch2=right
//  DEPTH   4   per-channel FIFO depth in words (power of two, >=2)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  in_valid   in   NUM_CH        per-channel push strobe, one word per channel per cycle
//  in_data    in   NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
//  ovf        out  NUM_CH        sticky per-channel overflow flag
//  out_valid  out  1             out_data/out_ch hold a word for the controller
//  out_data   out  WIDTH         selected word
//  out_ch     out  CH_W          source channel of out_data; CH_W = clog2(NUM_CH)
//  out_ready  in   1             controller accepts the word this cycle
// BEHAVIOUR
//  - Reset (sampled at posedge clk while reset=1): FIFOs empty, out_valid=0, out_data=0,
//    out_ch=0, ovf=0, rr pointer=NUM_CH-1 (ch0 wins first). Reset mid-transfer discards all data.
//  - Push: in_valid[c]=1 at edge writes in_data[c] to FIFO c. Full FIFO with no pop that
//    cycle: word dropped and ovf[c] set until reset. Full FIFO popped the same cycle: push accepted.
//  - Output register: loads when (!out_valid || out_ready). Holds out_data/out_ch stable
//    while out_valid=1 && out_ready=0.
//  - Arbitration on each load: scan channels from ptr+1 to ptr+NUM_CH, modulo NUM_CH.
//    Grant the first non-empty FIFO, pop it, set ptr to the granted channel. No grant:
//    out_valid=0 and ptr unchanged.
//  - Only FIFO contents are arbitrated; a word pushed at edge E is eligible at E+1 and
//    appears on out_valid after edge E+1 at the earliest. No combinational in->out path.
//  - Throughput: 1 word/cycle when out_ready=1 continuously. Round-robin bounds wait
//    to NUM_CH-1 grants per channel.
//  - FIFO pointers are clog2(DEPTH)+1 bits wide and wrap naturally; full = MSB differs
//    and the rest are equal.
// CONFIGURATION
//  - INGRESS_SELF_PRIO_EN defined: ch1 (self) has strict priority whenever non-empty,
//    and ptr is not updated on a self grant. Other channels use round-robin as above.
//  - Undefined: pure round-robin; self is treated like every other channel.
// STRUCTURE
//  - Shared header node_defs.vh: CH_LEFT=0, CH_SELF=1, CH_RIGHT=2, clog2 function,
//    default WIDTH.
//  - Sub-module ingress_fifo (WIDTH, DEPTH): sync FIFO, ports clk, reset, push, din,
//    pop, dout, empty, full. Instantiated NUM_CH times in a generate loop. Arbiter,
//    output register and ovf live in the top module.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=3'b111 -> out_valid=0, ovf=0; no word
//    appears afterwards.
//  2 Single push: ch2 pushes 0xA5A5_0001 at edge E, out_ready=1 -> out_valid=1 after
//    E+1, out_data=0xA5A5_0001, out_ch=2; out_valid=0 next cycle.
//  3 Fairness: all 3 FIFOs preloaded with 2 words, out_ready=1 -> out_ch sequence
//    0,1,2,0,1,2 (with INGRESS_SELF_PRIO_EN: 1,1,0,2,0,2).
//  4 Backpressure: out_ready=0 for 5 cycles with a word valid -> out_data/out_ch unchanged;
//    on release, the next word arrives one cycle later.
//  5 Overflow: out_ready=0, push ch0 DEPTH+2 times -> ovf=3'b001. Drain yields exactly
//    DEPTH words in order (after the held output word), with the later pushes missing.
//  6 Full push+pop: ch0 FIFO full, push while popped -> no ovf; word count unchanged.

Source files
------------

// File: rtl/ingress_rr_arbiter_pkg.sv
// Shared ring-node definitions: channel indices, default word width and a constant clog2 helper.
package ingress_rr_arbiter_pkg;

   localparam int CH_LEFT   = 0;
   localparam int CH_SELF   = 1;
   localparam int CH_RIGHT  = 2;
   localparam int DEF_WIDTH = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ingress_fifo.sv
// Synchronous per-channel ingress FIFO; pointers carry one extra wrap bit for full/empty.
module ingress_fifo
   import ingress_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_wr_en;
   logic w_rd_en;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A full FIFO still takes a push when the same edge frees a slot.
   assign w_rd_en = pop && !w_empty;
   assign w_wr_en = push && (!w_full || w_rd_en);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = r_mem[r_rd_ptr[AW-1:0]];
   assign empty = w_empty;
   assign full  = w_full;

endmodule

// File: rtl/ingress_rr_arbiter.sv
// Ring-node ingress: per-source FIFOs, round-robin arbiter and a registered valid/ready output.
// Build option INGRESS_SELF_PRIO_EN: the self channel wins whenever it holds a word.
module ingress_rr_arbiter
   import ingress_rr_arbiter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_CH = 3,
   parameter int DEPTH  = 4,
   localparam int CH_W  = clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       ovf,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]         out_ch,
   input  logic                    out_ready
);

   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_pop;
   logic [WIDTH-1:0]  w_dout [NUM_CH];

   logic              w_load;
   logic              w_gnt_vld;
   logic [CH_W-1:0]   w_gnt;
   logic              w_keep_ptr;
   int                w_idx;
   logic [CH_W-1:0]   w_scan;
   logic [NUM_CH-1:0] w_ovf_set;

   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic [CH_W-1:0]   r_out_ch;
   logic [CH_W-1:0]   r_ptr;
   logic [NUM_CH-1:0] r_ovf;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
      ingress_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (in_valid[c]),
         .din   (in_data[c*WIDTH +: WIDTH]),
         .pop   (w_pop[c]),
         .dout  (w_dout[c]),
         .empty (w_empty[c]),
         .full  (w_full[c])
      );
   end

   assign w_load = !r_out_valid || out_ready;

   // Scan starts just past the last granted channel, so every source waits at most NUM_CH-1 grants.
   always_comb begin
      w_gnt_vld  = 1'b0;
      w_gnt      = '0;
      w_keep_ptr = 1'b0;
      w_idx      = 0;
      w_scan     = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         w_idx = int'(r_ptr) + i;
         if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
         w_scan = CH_W'(w_idx);
         if (!w_gnt_vld && !w_empty[w_scan]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_scan;
         end
      end
`ifdef INGRESS_SELF_PRIO_EN
      if (!w_empty[CH_SELF]) begin
         w_gnt_vld  = 1'b1;
         w_gnt      = CH_W'(CH_SELF);
         w_keep_ptr = 1'b1;
      end
`endif
   end

   always_comb begin
      w_pop = '0;
      if (w_load && w_gnt_vld) w_pop[w_gnt] = 1'b1;
   end

   assign w_ovf_set = in_valid & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= CH_W'(NUM_CH - 1);
         r_ovf       <= '0;
      end else begin
         r_ovf <= r_ovf | w_ovf_set;
         if (w_load) begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
               r_out_data <= w_dout[w_gnt];
               r_out_ch   <= w_gnt;
               if (!w_keep_ptr) r_ptr <= w_gnt;
            end
         end
      end
   end

   assign ovf       = r_ovf;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// Scoreboard bench for ingress_rr_arbiter; honours INGRESS_SELF_PRIO_EN for the fairness order.
module tb_ingress_rr_arbiter;

   localparam int WIDTH  = 32;
   localparam int NUM_CH = 3;
   localparam int DEPTH  = 4;

   logic                    clk;
   logic                    reset;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       ovf;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [1:0]              out_ch;
   logic                    out_ready;

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_pass;
   int   n_total;

   ingress_rr_arbiter #(
      .WIDTH  (WIDTH),
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      sb.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 3'b111;
      in_data   = {$urandom, $urandom, $urandom};
      out_ready = 1'b1;
      tick();
      tick();
      reset    = 1'b0;
      in_valid = '0;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (ovf !== 3'b000) $display("FAIL reset_ovf got %b want 000", ovf);
      else n_pass++;
      n_total++;
      if (out_data !== 32'h0 || out_ch !== 2'd0)
         $display("FAIL reset_out got data=%h ch=%0d want data=0 ch=0", out_data, out_ch);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_total++;
         if (out_valid !== 1'b0) $display("FAIL reset_noword%0d got valid=%b want 0", i, out_valid);
         else n_pass++;
      end
   endtask

   task automatic test_single_push();
      do_reset();
      out_ready = 1'b1;
      in_data[2*WIDTH +: WIDTH] = 32'hA5A5_0001;
      in_valid = 3'b100;
      sb.push_back('{ch: 2'd2, data: 32'hA5A5_0001});
      tick();
      in_valid = '0;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL single_latency got valid=%b want 0", out_valid);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_ch !== e.ch || out_data !== e.data)
         $display("FAIL single_word got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h",
                  out_valid, out_ch, out_data, e.ch, e.data);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL single_after got valid=%b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_fairness();
      int exp_ch [6];
      int exp_wd [6];
`ifdef INGRESS_SELF_PRIO_EN
      exp_ch = '{1, 1, 0, 2, 0, 2};
      exp_wd = '{0, 1, 0, 0, 1, 1};
`else
      exp_ch = '{0, 1, 2, 0, 1, 2};
      exp_wd = '{0, 0, 0, 1, 1, 1};
`endif
      do_reset();
      for (int k = 0; k < 2; k++) begin
         in_valid = 3'b111;
         for (int c = 0; c < NUM_CH; c++) in_data[c*WIDTH +: WIDTH] = 32'hF000_0000 | (c << 8) | k;
         tick();
      end
      in_valid = '0;
      for (int n = 0; n < 6; n++)
         sb.push_back('{ch: 2'(exp_ch[n]), data: 32'hF000_0000 | (exp_ch[n] << 8) | exp_wd[n]});
      tick();
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         e = sb.pop_front();
         n_total++;
         if (out_valid !== 1'b1 || out_ch !== e.ch || out_data !== e.data)
            $display("FAIL fair_word%0d got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h",
                     n, out_valid, out_ch, out_data, e.ch, e.data);
         else n_pass++;
         tick();
      end
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL fair_idle got valid=%b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 3'b010;
      in_data[1*WIDTH +: WIDTH] = 32'hB0B0_0000;
      sb.push_back('{ch: 2'd1, data: 32'hB0B0_0000});
      tick();
      in_data[1*WIDTH +: WIDTH] = 32'hB0B0_0001;
      sb.push_back('{ch: 2'd1, data: 32'hB0B0_0001});
      tick();
      in_valid = '0;
      e = sb[0];
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_ch !== e.ch || out_data !== e.data)
            $display("FAIL bp_hold%0d got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h",
                     i, out_valid, out_ch, out_data, e.ch, e.data);
         else n_pass++;
         tick();
      end
      out_ready = 1'b1;
      for (int n = 0; n < 2; n++) begin
         e = sb.pop_front();
         n_total++;
         if (out_valid !== 1'b1 || out_ch !== e.ch || out_data !== e.data)
            $display("FAIL bp_release%0d got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h",
                     n, out_valid, out_ch, out_data, e.ch, e.data);
         else n_pass++;
         tick();
      end
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL bp_idle got valid=%b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_overflow();
      int got;
      do_reset();
      for (int k = 0; k < DEPTH + 2; k++) begin
         in_valid = 3'b001;
         in_data[0 +: WIDTH] = 32'h0F00_0000 + k;
         if (k <= DEPTH) sb.push_back('{ch: 2'd0, data: 32'h0F00_0000 + k});
         tick();
      end
      in_valid = '0;
      n_total++;
      if (ovf !== 3'b001) $display("FAIL ovf_flag got %b want 001", ovf);
      else n_pass++;
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 4 * DEPTH; cyc++) begin
         if (out_valid) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL ovf_extra got ch=%0d data=%h want no word", out_ch, out_data);
            end else begin
               e = sb.pop_front();
               if (out_ch !== e.ch || out_data !== e.data)
                  $display("FAIL ovf_word%0d got ch=%0d data=%h want ch=%0d data=%h",
                           got, out_ch, out_data, e.ch, e.data);
               else n_pass++;
            end
            got++;
         end
         tick();
      end
      n_total++;
      if (got != DEPTH + 1) $display("FAIL ovf_count got %0d words want %0d", got, DEPTH + 1);
      else n_pass++;
      n_total++;
      if (ovf !== 3'b001) $display("FAIL ovf_sticky got %b want 001", ovf);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      int got;
      do_reset();
      for (int k = 0; k <= DEPTH; k++) begin
         in_valid = 3'b001;
         in_data[0 +: WIDTH] = 32'h5500_0000 + k;
         sb.push_back('{ch: 2'd0, data: 32'h5500_0000 + k});
         tick();
      end
      in_data[0 +: WIDTH] = 32'h5500_0000 + DEPTH + 1;
      sb.push_back('{ch: 2'd0, data: 32'h5500_0000 + DEPTH + 1});
      out_ready = 1'b1;
      e = sb.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_ch !== e.ch || out_data !== e.data)
         $display("FAIL fpp_held got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h",
                  out_valid, out_ch, out_data, e.ch, e.data);
      else n_pass++;
      tick();
      in_valid = '0;
      n_total++;
      if (ovf !== 3'b000) $display("FAIL fpp_ovf got %b want 000", ovf);
      else n_pass++;
      got = 0;
      for (int cyc = 0; cyc < 4 * DEPTH; cyc++) begin
         if (out_valid) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL fpp_extra got ch=%0d data=%h want no word", out_ch, out_data);
            end else begin
               e = sb.pop_front();
               if (out_ch !== e.ch || out_data !== e.data)
                  $display("FAIL fpp_word%0d got ch=%0d data=%h want ch=%0d data=%h",
                           got, out_ch, out_data, e.ch, e.data);
               else n_pass++;
            end
            got++;
         end
         tick();
      end
      n_total++;
      if (got != DEPTH + 1) $display("FAIL fpp_count got %0d words want %0d", got, DEPTH + 1);
      else n_pass++;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_single_push();
      test_fairness();
      test_backpressure();
      test_overflow();
      test_full_push_pop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
